// File: rtl/negate_serial.sv
// Serial two's-complement negation unit, BPC bits per cycle, LSB first, valid/ready on both sides.
// Optional overflow flag output is enabled by defining NEGATE_OVF_FLAG_EN.
module negate_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic             in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             busy
`ifdef NEGATE_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NCHUNK = WIDTH / BPC;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    NEG,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic             seen_one;
  logic             seen_acc;
  logic [IDXW-1:0]  idx;
  logic [BPC-1:0]   chunk_res;

  // Bits copy until the first 1 has been seen (inclusive), then invert.
  // Result chunks enter at the MSB end so the register holds -x after NCHUNK shifts.
  always_comb begin
    seen_acc  = seen_one;
    chunk_res = '0;
    for (int unsigned i = 0; i < BPC; i++) begin
      chunk_res[i] = shreg[i] ^ seen_acc;
      seen_acc     = seen_acc | shreg[i];
    end
    shreg_nxt = (shreg >> BPC) | (WIDTH'(chunk_res) << (WIDTH - BPC));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = in_neg ? NEG : DONE;
      NEG:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      seen_one <= 1'b0;
      idx      <= '0;
      out_res  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_neg) begin
              shreg    <= in_num;
              seen_one <= 1'b0;
              idx      <= '0;
            end else begin
              out_res  <= in_num;
            end
          end
        end
        NEG: begin
          shreg    <= shreg_nxt;
          seen_one <= seen_acc;
          idx      <= idx + 1'b1;
          if (idx == LAST_IDX) out_res <= shreg_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef NEGATE_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ovf <= in_neg && (in_num == {1'b1, {(WIDTH-1){1'b0}}});
    end else if (state == DONE && out_ready) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_negate_serial.sv
// Bench for negate_serial: BPC=1 and BPC=4 instances, directed table plus random sweep vs -x.
module tb_negate_serial;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv[2];
  logic [W-1:0] inum[2];
  logic         ineg[2];
  logic         ordy[2];

  logic         ir0, ir1, ov0, ov1, bz0, bz1;
  logic [W-1:0] res0, res1;
`ifdef NEGATE_OVF_FLAG_EN
  logic         of0, of1;
`endif

  negate_serial #(.WIDTH(32), .BPC(1)) dut0 (
    .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir0), .in_num(inum[0]),
    .in_neg(ineg[0]), .out_valid(ov0), .out_ready(ordy[0]), .out_res(res0), .busy(bz0)
`ifdef NEGATE_OVF_FLAG_EN
    , .ovf(of0)
`endif
  );

  negate_serial #(.WIDTH(32), .BPC(4)) dut1 (
    .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir1), .in_num(inum[1]),
    .in_neg(ineg[1]), .out_valid(ov1), .out_ready(ordy[1]), .out_res(res1), .busy(bz1)
`ifdef NEGATE_OVF_FLAG_EN
    , .ovf(of1)
`endif
  );

  function automatic logic [W-1:0] f_res(int s);
    return (s == 0) ? res0 : res1;
  endfunction
  function automatic logic f_valid(int s);
    return (s == 0) ? ov0 : ov1;
  endfunction
  function automatic logic f_ready(int s);
    return (s == 0) ? ir0 : ir1;
  endfunction
  function automatic logic f_busy(int s);
    return (s == 0) ? bz0 : bz1;
  endfunction
`ifdef NEGATE_OVF_FLAG_EN
  function automatic logic f_ovf(int s);
    return (s == 0) ? of0 : of1;
  endfunction
`endif

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Called and returns at a negedge with the instance idle; exp/lat come from the caller.
  task automatic run_op(int s, logic [W-1:0] num, logic neg, logic [W-1:0] exp, int lat, int hold);
    int   k;
    logic exp_ovf;
    exp_ovf = neg && (num == 32'h8000_0000);
    chk("in_ready_idle", W'(f_ready(s)), 32'd1);
    iv[s]   = 1'b1;
    inum[s] = num;
    ineg[s] = neg;
    ordy[s] = 1'b0;
    @(negedge clk);
    iv[s]   = 1'b0;
    inum[s] = $urandom;
    ineg[s] = 1'($urandom_range(0, 1));
    k = 1;
    while (!f_valid(s) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("latency", W'(k), W'(lat));
    chk("result", f_res(s), exp);
    chk("in_ready_done", W'(f_ready(s)), 32'd0);
    chk("busy_done", W'(f_busy(s)), 32'd1);
`ifdef NEGATE_OVF_FLAG_EN
    chk("ovf", W'(f_ovf(s)), W'(exp_ovf));
`endif
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", W'(f_valid(s)), 32'd1);
      chk("hold_result", f_res(s), exp);
      chk("hold_in_ready", W'(f_ready(s)), 32'd0);
    end
    ordy[s] = 1'b1;
    @(negedge clk);
    ordy[s] = 1'b0;
    chk("valid_after_hs", W'(f_valid(s)), 32'd0);
    chk("busy_after_hs", W'(f_busy(s)), 32'd0);
    chk("in_ready_after_hs", W'(f_ready(s)), 32'd1);
`ifdef NEGATE_OVF_FLAG_EN
    chk("ovf_cleared", W'(f_ovf(s)), 32'd0);
`endif
  endtask

  typedef struct {
    int           sel;
    logic [W-1:0] num;
    logic         neg;
    logic [W-1:0] exp;
    int           lat;
    int           hold;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] num, exp;
    logic         neg, seen_valid;
    int           s;

    tbl[0] = '{0, 32'd5,          1'b1, 32'hFFFF_FFFB, 33, 0};
    tbl[1] = '{0, 32'h0000_1234,  1'b0, 32'h0000_1234,  1, 0};
    tbl[2] = '{0, 32'd0,          1'b1, 32'd0,         33, 0};
    tbl[3] = '{0, 32'h8000_0000,  1'b1, 32'h8000_0000, 33, 0};
    tbl[4] = '{0, 32'h0000_0100,  1'b1, 32'hFFFF_FF00, 33, 5};
    tbl[5] = '{0, 32'h0000_0001,  1'b1, 32'hFFFF_FFFF, 33, 0};
    tbl[6] = '{1, 32'h0000_0010,  1'b1, 32'hFFFF_FFF0,  9, 0};
    tbl[7] = '{1, 32'h7FFF_FFFF,  1'b1, 32'h8000_0001,  9, 2};
    tbl[8] = '{1, 32'h0000_ABCD,  1'b0, 32'h0000_ABCD,  1, 3};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; inum[i] = '0; ineg[i] = 1'b0; ordy[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_out_valid", W'(f_valid(i)), 32'd0);
      chk("reset_in_ready", W'(f_ready(i)), 32'd1);
      chk("reset_busy", W'(f_busy(i)), 32'd0);
      chk("reset_out_res", f_res(i), 32'd0);
`ifdef NEGATE_OVF_FLAG_EN
      chk("reset_ovf", W'(f_ovf(i)), 32'd0);
`endif
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_op(tbl[i].sel, tbl[i].num, tbl[i].neg, tbl[i].exp, tbl[i].lat, tbl[i].hold);

    // Reset in the middle of a negate: result discarded, unit idle next cycle.
    iv[0] = 1'b1; inum[0] = 32'h0000_1234; ineg[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_out_valid", W'(ov0), 32'd0);
    chk("midreset_in_ready", W'(ir0), 32'd1);
    chk("midreset_busy", W'(bz0), 32'd0);
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_valid = seen_valid | ov0;
    end
    chk("midreset_no_valid", W'(seen_valid), 32'd0);
    run_op(0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 33, 0);

    // Random sweep against plain modular negation.
    for (int i = 0; i < 1100; i++) begin
      s   = (i < 1000) ? 1 : 0;
      num = $urandom;
      if (i % 97 == 3) num = 32'h8000_0000;
      if (i % 89 == 5) num = 32'd0;
      neg = 1'($urandom_range(0, 1));
      exp = neg ? (32'd0 - num) : num;
      run_op(s, num, neg, exp, neg ? (W / ((s == 0) ? 1 : 4) + 1) : 1, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
